// File: rtl/xadc_drp_sampler.sv
// XADC DRP sampler: on each end-of-conversion, reads the voltage and current result registers
// over DRP and presents the 12-bit samples on two independent AXI-Stream outputs.
`timescale 1ns/1ps

module xadc_drp_sampler #(
  parameter logic [6:0]  VOLTAGE_ADDR = 7'h13,
  parameter logic [6:0]  CURRENT_ADDR = 7'h1B,
  parameter int unsigned DRDY_TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        eoc,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [6:0]  drp_daddr,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        voltage_tvalid,
  input  logic        voltage_tready,
  output logic [15:0] voltage_tdata,
  output logic        current_tvalid,
  input  logic        current_tready,
  output logic [15:0] current_tdata,
  output logic [15:0] overrun_count,
  output logic [15:0] timeout_count
);

  // state  | meaning
  // IDLE   | waiting for eoc
  // RD_V   | DRP read strobe, voltage address
  // WAIT_V | waiting for drdy of voltage read
  // RD_I   | DRP read strobe, current address
  // WAIT_I | waiting for drdy of current read
  // PUSH   | hand the pair to the streams, or drop it
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_V   = 3'd1,
    S_WAIT_V = 3'd2,
    S_RD_I   = 3'd3,
    S_WAIT_I = 3'd4,
    S_PUSH   = 3'd5
  } state_t;

  localparam int unsigned TW = (DRDY_TIMEOUT > 1) ? $clog2(DRDY_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'((DRDY_TIMEOUT > 0) ? DRDY_TIMEOUT - 1 : 0);

  state_t         state, state_nx;
  logic [TW-1:0]  tmr;
  logic [11:0]    hold_v, hold_i;
  logic           cap_v, cap_i, timeout_hit, push;
  logic           push_ok, push_drop, eoc_ovr;
  logic [1:0]     ovr_inc;
  logic [16:0]    ovr_sum;
  logic           unused_drp_lsb;

  assign drp_dwe        = 1'b0;
  assign drp_di         = 16'h0000;
  assign unused_drp_lsb = ^drp_do[3:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // drdy is accepted for DRDY_TIMEOUT-1 wait cycles, so a missing response is
  // counted DRDY_TIMEOUT cycles after the den strobe.
  always_comb begin
    state_nx    = state;
    drp_den     = 1'b0;
    drp_daddr   = 7'h00;
    cap_v       = 1'b0;
    cap_i       = 1'b0;
    timeout_hit = 1'b0;
    push        = 1'b0;
    case (state)
      S_IDLE: begin
        if (eoc) state_nx = S_RD_V;
      end
      S_RD_V: begin
        drp_den   = 1'b1;
        drp_daddr = VOLTAGE_ADDR;
        state_nx  = S_WAIT_V;
      end
      S_WAIT_V: begin
        if (drp_drdy) begin
          cap_v    = 1'b1;
          state_nx = S_RD_I;
        end else if (tmr <= TW'(1)) begin
          timeout_hit = 1'b1;
          state_nx    = S_IDLE;
        end
      end
      S_RD_I: begin
        drp_den   = 1'b1;
        drp_daddr = CURRENT_ADDR;
        state_nx  = S_WAIT_I;
      end
      S_WAIT_I: begin
        if (drp_drdy) begin
          cap_i    = 1'b1;
          state_nx = S_PUSH;
        end else if (tmr <= TW'(1)) begin
          timeout_hit = 1'b1;
          state_nx    = S_IDLE;
        end
      end
      S_PUSH: begin
        push     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr <= '0;
    end else if (state == S_RD_V || state == S_RD_I) begin
      tmr <= TMR_LOAD;
    end else if (tmr != '0) begin
      tmr <= tmr - TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_v <= 12'h000;
      hold_i <= 12'h000;
    end else begin
      if (cap_v) hold_v <= drp_do[15:4];
      if (cap_i) hold_i <= drp_do[15:4];
    end
  end

  // A pair is only published when both streams are empty, keeping V and I aligned.
  assign push_ok   = push && !voltage_tvalid && !current_tvalid;
  assign push_drop = push && !push_ok;
  assign eoc_ovr   = eoc && (state != S_IDLE);
  assign ovr_inc   = {1'b0, eoc_ovr} + {1'b0, push_drop};
  assign ovr_sum   = {1'b0, overrun_count} + {15'd0, ovr_inc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      voltage_tvalid <= 1'b0;
      voltage_tdata  <= 16'h0000;
    end else if (push_ok) begin
      voltage_tvalid <= 1'b1;
      voltage_tdata  <= {4'h0, hold_v};
    end else if (voltage_tvalid && voltage_tready) begin
      voltage_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      current_tvalid <= 1'b0;
      current_tdata  <= 16'h0000;
    end else if (push_ok) begin
      current_tvalid <= 1'b1;
      current_tdata  <= {4'h0, hold_i};
    end else if (current_tvalid && current_tready) begin
      current_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun_count <= 16'h0000;
      timeout_count <= 16'h0000;
    end else begin
      overrun_count <= ovr_sum[16] ? 16'hFFFF : ovr_sum[15:0];
      if (timeout_hit && timeout_count != 16'hFFFF)
        timeout_count <= timeout_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_xadc_drp_sampler.sv
// Directed bench for xadc_drp_sampler: a DRP responder model feeds samples, a scoreboard
// queue holds the expected stream words and a monitor pops them on each handshake.
`timescale 1ns/1ps

module tb_xadc_drp_sampler;

  localparam int T = 63;

  logic        clk = 1'b0;
  logic        rst;
  logic        eoc;
  logic        drp_den, drp_dwe;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_drdy;
  logic        voltage_tvalid, voltage_tready;
  logic [15:0] voltage_tdata;
  logic        current_tvalid, current_tready;
  logic [15:0] current_tdata;
  logic [15:0] overrun_count, timeout_count;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_ovr  = 0;
  int exp_to   = 0;

  logic [15:0] q_v[$];
  logic [15:0] q_i[$];

  logic [15:0] v_data, i_data;
  int          resp_delay;
  logic        skip_v;

  xadc_drp_sampler dut (
    .clk(clk), .rst(rst), .eoc(eoc),
    .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_daddr(drp_daddr), .drp_di(drp_di),
    .drp_do(drp_do), .drp_drdy(drp_drdy),
    .voltage_tvalid(voltage_tvalid), .voltage_tready(voltage_tready), .voltage_tdata(voltage_tdata),
    .current_tvalid(current_tvalid), .current_tready(current_tready), .current_tdata(current_tdata),
    .overrun_count(overrun_count), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_eoc();
    eoc = 1'b1;
    tick();
    eoc = 1'b0;
  endtask

  task automatic expect_pair(input logic [15:0] v, input logic [15:0] i);
    v_data = v;
    i_data = i;
    q_v.push_back({4'h0, v[15:4]});
    q_i.push_back({4'h0, i[15:4]});
  endtask

  // DRP slave model: answers each den after resp_delay cycles.
  always begin : drp_responder
    logic [15:0] dat;
    @(negedge clk);
    if (drp_den && !(skip_v && drp_daddr == 7'h13)) begin
      dat = (drp_daddr == 7'h13) ? v_data : i_data;
      repeat (resp_delay) @(posedge clk);
      #1;
      drp_drdy = 1'b1;
      drp_do   = dat;
      @(posedge clk);
      #1;
      drp_drdy = 1'b0;
      drp_do   = 16'h0000;
    end
  end

  always @(negedge clk) begin
    if (rst && voltage_tvalid && voltage_tready) begin
      if (q_v.size() == 0) chk("v_unexpected_beat", 32'd1, 32'd0);
      else chk("v_stream_data", {16'h0, voltage_tdata}, {16'h0, q_v.pop_front()});
    end
    if (rst && current_tvalid && current_tready) begin
      if (q_i.size() == 0) chk("i_unexpected_beat", 32'd1, 32'd0);
      else chk("i_stream_data", {16'h0, current_tdata}, {16'h0, q_i.pop_front()});
    end
  end

  initial begin
    rst = 1'b0; eoc = 1'b0; drp_do = 16'h0000; drp_drdy = 1'b0;
    voltage_tready = 1'b1; current_tready = 1'b1;
    v_data = 16'h0; i_data = 16'h0; resp_delay = 1; skip_v = 1'b0;
    tick(); tick();

    // reset values
    chk("rst_den", {31'h0, drp_den}, 32'd0);
    chk("rst_daddr", {25'h0, drp_daddr}, 32'd0);
    chk("rst_vvalid", {31'h0, voltage_tvalid}, 32'd0);
    chk("rst_ivalid", {31'h0, current_tvalid}, 32'd0);
    chk("rst_vdata", {16'h0, voltage_tdata}, 32'd0);
    chk("rst_idata", {16'h0, current_tdata}, 32'd0);
    chk("rst_ovr", {16'h0, overrun_count}, 32'd0);
    chk("rst_to", {16'h0, timeout_count}, 32'd0);
    rst = 1'b1;
    tick();

    // nominal
    expect_pair(16'hABC0, 16'h1230);
    pulse_eoc();
    chk("nom_den_v", {31'h0, drp_den}, 32'd1);
    chk("nom_addr_v", {25'h0, drp_daddr}, 32'h13);
    chk("nom_dwe", {31'h0, drp_dwe}, 32'd0);
    chk("nom_di", {16'h0, drp_di}, 32'd0);
    tick();
    chk("nom_den_wait", {31'h0, drp_den}, 32'd0);
    chk("nom_addr_wait", {25'h0, drp_daddr}, 32'd0);
    tick();
    chk("nom_addr_i", {25'h0, drp_daddr}, 32'h1B);
    tick(); tick();
    chk("nom_early_vvalid", {31'h0, voltage_tvalid}, 32'd0);
    tick();
    chk("nom_vvalid", {31'h0, voltage_tvalid}, 32'd1);
    chk("nom_ivalid", {31'h0, current_tvalid}, 32'd1);
    chk("nom_vdata", {16'h0, voltage_tdata}, 32'h0ABC);
    chk("nom_idata", {16'h0, current_tdata}, 32'h0123);
    tick();
    chk("nom_vvalid_clr", {31'h0, voltage_tvalid}, 32'd0);
    chk("nom_ivalid_clr", {31'h0, current_tvalid}, 32'd0);

    // backpressure: second pair dropped
    voltage_tready = 1'b0; current_tready = 1'b0;
    expect_pair(16'h1110, 16'h2220);
    pulse_eoc();
    repeat (5) tick();
    chk("bp_vvalid", {31'h0, voltage_tvalid}, 32'd1);
    chk("bp_vdata", {16'h0, voltage_tdata}, 32'h0111);
    repeat (14) tick();
    v_data = 16'hFFF0; i_data = 16'hEEE0;
    pulse_eoc();
    repeat (6) tick();
    exp_ovr++;
    chk("bp_ovr", {16'h0, overrun_count}, exp_ovr);
    chk("bp_vdata_held", {16'h0, voltage_tdata}, 32'h0111);
    chk("bp_idata_held", {16'h0, current_tdata}, 32'h0222);
    chk("bp_ivalid_held", {31'h0, current_tvalid}, 32'd1);
    voltage_tready = 1'b1; current_tready = 1'b1;
    tick(); tick();
    chk("bp_vvalid_clr", {31'h0, voltage_tvalid}, 32'd0);
    chk("bp_ivalid_clr", {31'h0, current_tvalid}, 32'd0);

    // timeout on voltage read
    skip_v = 1'b1;
    pulse_eoc();
    repeat (T - 1) tick();
    chk("to_before", {16'h0, timeout_count}, exp_to);
    tick();
    exp_to++;
    chk("to_count", {16'h0, timeout_count}, exp_to);
    chk("to_no_vvalid", {31'h0, voltage_tvalid}, 32'd0);
    chk("to_no_ivalid", {31'h0, current_tvalid}, 32'd0);
    skip_v = 1'b0;
    tick(); tick();
    chk("to_idle_den", {31'h0, drp_den}, 32'd0);
    expect_pair(16'h7770, 16'h8880);
    pulse_eoc();
    repeat (5) tick();
    chk("to_next_vvalid", {31'h0, voltage_tvalid}, 32'd1);
    chk("to_next_idata", {16'h0, current_tdata}, 32'h0888);
    tick();

    // eoc during WAIT_I
    expect_pair(16'h3210, 16'h4560);
    pulse_eoc();
    repeat (3) tick();
    pulse_eoc();
    tick();
    exp_ovr++;
    chk("wi_ovr", {16'h0, overrun_count}, exp_ovr);
    chk("wi_idata", {16'h0, current_tdata}, 32'h0456);
    chk("wi_vdata", {16'h0, voltage_tdata}, 32'h0321);
    tick(); tick();

    // skewed consumers
    current_tready = 1'b0;
    expect_pair(16'h9990, 16'hAAA0);
    pulse_eoc();
    repeat (5) tick();
    chk("sk_ivalid", {31'h0, current_tvalid}, 32'd1);
    tick();
    chk("sk_vvalid_clr", {31'h0, voltage_tvalid}, 32'd0);
    v_data = 16'h1010; i_data = 16'h2020;
    pulse_eoc();
    repeat (6) tick();
    exp_ovr++;
    chk("sk_ovr", {16'h0, overrun_count}, exp_ovr);
    chk("sk_idata_held", {16'h0, current_tdata}, 32'h0AAA);
    chk("sk_vvalid_still0", {31'h0, voltage_tvalid}, 32'd0);
    current_tready = 1'b1;
    tick(); tick();
    chk("sk_ivalid_clr", {31'h0, current_tvalid}, 32'd0);

    // reset in WAIT_V, late drdy after release
    resp_delay = 4;
    v_data = 16'h5550; i_data = 16'h6660;
    pulse_eoc();
    tick();
    rst = 1'b0;
    #1;
    exp_ovr = 0; exp_to = 0;
    chk("mr_ovr", {16'h0, overrun_count}, exp_ovr);
    chk("mr_to", {16'h0, timeout_count}, exp_to);
    chk("mr_vdata", {16'h0, voltage_tdata}, 32'd0);
    tick();
    rst = 1'b1;
    repeat (8) tick();
    chk("mr_den", {31'h0, drp_den}, 32'd0);
    chk("mr_vvalid", {31'h0, voltage_tvalid}, 32'd0);
    chk("mr_ivalid", {31'h0, current_tvalid}, 32'd0);
    chk("mr_idata", {16'h0, current_tdata}, 32'd0);
    chk("mr_ovr_after", {16'h0, overrun_count}, exp_ovr);
    resp_delay = 1;

    // fresh sequence after reset
    expect_pair(16'hC0D0, 16'hE0F0);
    pulse_eoc();
    repeat (5) tick();
    chk("fr_vdata", {16'h0, voltage_tdata}, 32'h0C0D);
    chk("fr_idata", {16'h0, current_tdata}, 32'h0E0F);
    tick(); tick();

    chk("q_v_drained", q_v.size(), 32'd0);
    chk("q_i_drained", q_i.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/xadc_drp_sampler.md
XADC_DRP_SAMPLER -- requirements
Module: xadc_drp_sampler

Interface
REQ-001 SHALL have parameter VOLTAGE_ADDR, default 7'h13, DRP address of the voltage-channel result register.
REQ-002 SHALL have parameter CURRENT_ADDR, default 7'h1B, DRP address of the current-monitor result register.
REQ-003 SHALL have parameter DRDY_TIMEOUT, default 63, maximum cycles to wait for drp_drdy.
REQ-004 SHALL have ports:
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- eoc  in  1  XADC end-of-conversion pulse.
- drp_den  out  1  DRP enable.
- drp_dwe  out  1  DRP write enable.
- drp_daddr  out  7  DRP address.
- drp_di  out  16  DRP write data.
- drp_do  in  16  DRP read data.
- drp_drdy  in  1  DRP data ready.
- voltage_tvalid / voltage_tready / voltage_tdata  out / in / out  1/1/16  voltage sample stream.
- current_tvalid / current_tready / current_tdata  out / in / out  1/1/16  current sample stream.
- overrun_count  out  16  saturating count of dropped sample pairs.
- timeout_count  out  16  saturating count of DRP read timeouts.

Function
REQ-005 SHALL implement FSM IDLE -> RD_V -> WAIT_V -> RD_I -> WAIT_I -> PUSH -> IDLE.
REQ-006 IDLE: on eoc=1, SHALL go to RD_V next cycle.
REQ-007 RD_V: drp_den=1 and drp_daddr=VOLTAGE_ADDR for exactly one cycle; next state WAIT_V.
REQ-008 WAIT_V: on drp_drdy=1, SHALL capture drp_do[15:4] into the voltage holding register and go to RD_I.
REQ-009 RD_I / WAIT_I: SHALL behave as RD_V / WAIT_V using CURRENT_ADDR and the current holding register; next state PUSH.
REQ-010 drp_dwe SHALL always be 0 and drp_di always 16'h0000; drp_daddr SHALL be 7'h00 outside RD_V/RD_I.
REQ-011 In WAIT_V/WAIT_I, if drp_drdy does not arrive within DRDY_TIMEOUT cycles after den, SHALL increment timeout_count (saturating at 16'hFFFF), discard the pair, and return to IDLE; no stream output.
REQ-012 PUSH: if voltage_tvalid=0 and current_tvalid=0, SHALL load both tdata = {4'h0, sample[11:0]} and set both tvalid=1 in the same cycle.
REQ-013 PUSH: if either tvalid=1 (the previous pair is not fully consumed), SHALL drop the new pair, leave outputs unchanged, and increment overrun_count (saturating).
REQ-014 eoc asserted in any state other than IDLE SHALL be ignored and SHALL increment overrun_count (saturating); in IDLE, eoc is consumed without counting.
REQ-015 Each output SHALL follow AXI-Stream rules independently.
- tdata stable while tvalid=1 and tready=0.
- tvalid clears the cycle after a tvalid&&tready handshake.
- tvalid never depends combinationally on tready.
REQ-016 Latency: eoc to both tvalid=1 SHALL be 6 cycles with drdy returned one cycle after each den.
REQ-017 A drp_drdy outside WAIT_V/WAIT_I SHALL be ignored.

Reset
REQ-018 While rst=0, the block SHALL immediately hold state IDLE.
- drp_den=0, drp_daddr=0, both tvalid=0, both tdata=0.
- overrun_count=0, timeout_count=0, holding registers=0.
REQ-019 rst asserted mid-transaction (any state) SHALL abort with no output.
REQ-020 After rst deasserts, the first eoc SHALL start a fresh sequence.

Verification
REQ-021 Nominal: eoc pulse; drdy 1 cycle after each den, drp_do=16'hABC0 (V), 16'h1230 (I); tready=1 -> voltage_tdata=16'h0ABC, current_tdata=16'h0123 6 cycles after eoc; both tvalid for 1 cycle.
REQ-022 Backpressure: tready=0 on both, two eoc pulses 20 cycles apart -> first pair held stable, overrun_count=1; raising tready delivers only the first pair.
REQ-023 Timeout: drdy never asserted for the voltage read -> timeout_count=1 at cycle DRDY_TIMEOUT after den; FSM in IDLE; no tvalid; the next eoc completes normally.
REQ-024 eoc during WAIT_I -> overrun_count=1; current sample still delivered correctly.
REQ-025 Reset in WAIT_V with drdy arriving after release -> drdy ignored, outputs 0, counters 0.
REQ-026 Skewed consumers: current_tready=0 for 10 cycles while voltage handshakes at once -> current_tdata held; an eoc in that window counts an overrun.
